colour_sequence_engine: RTL
===========================

// Module: colour_sequence_engine
// PURPOSE
//  Parametrised Simon-style game core for the ColourMemory LT24 design.
//  - Generates pseudo-random colour sequences from an LFSR; no fixed sequence.
//  - Each level shows the first L entries, then checks L keypresses; on success the length grows by one.
//  - Drives colour/screen codes to the pixel mux and score/level to the seven-segment path.
// PARAMETERS
//  NUM_KEYS       4         keys/colours; power of 2, 2..8; IDXW=log2(NUM_KEYS)
//  MAX_LEN        16        longest sequence (final level), 1..255
//  START_LEN      2         sequence length at level 1, 1..MAX_LEN
//  FLASH_CYCLES   25000000  cycles each colour is lit during SHOW
//  GAP_CYCLES     5000000   dark cycles between flashed colours
//  TIMEOUT_CYCLES 0         max idle cycles in INPUT before game over; 0 disables
//  SCORE_MAX      99        score saturation value (two-digit display)
//  LFSR_SEED      16'hACE1  free-running LFSR reset value, nonzero
// PORTS
//  clock          in   1        system clock
//  reset          in   1        synchronous, active-high
//  key            in   NUM_KEYS active-high, already single-key filtered (at most one bit set)
//  colour_onehot  out  NUM_KEYS lit colour, one-hot; 0 = black
//  screen         out  2        0 colour, 1 intro, 2 level complete, 3 game over
//  level          out  8        current sequence length L
//  score          out  7        correct presses this game, saturating
//  showing        out  1        high in SHOW_ON/SHOW_GAP (keys ignored)
// BEHAVIOUR
//  - All outputs registered; reset: colour_onehot=0, screen=1, level=START_LEN, score=0, showing=0, state=IDLE.
//  - Reset mid-operation returns to IDLE within one cycle. The free LFSR reloads LFSR_SEED.
//  - LFSR: 16-bit Galois, taps 16'hB400, stepped every cycle.
//  - Press = key!=0 while previous-cycle key==0.
//  - PRESS state waits for key==0, then enters the pending state.
//  - IDLE: screen=1.
//    - Press: game_seed<=lfsr (16'h0001 if zero), score<=0, level<=START_LEN, pending=SHOW.
//  - SHOW entry: replay LFSR<=game_seed, idx<=0.
//    - SHOW_ON: colour_onehot = 1<<replay[IDXW-1:0] for FLASH_CYCLES cycles.
//    - SHOW_GAP: black for GAP_CYCLES cycles, then idx++ and replay steps.
//    - After idx reaches L: reload replay from game_seed, idx<=0, timer<=0, go to INPUT.
//  - INPUT: screen=0, colour black. timer counts cycles; it clears on each accepted press.
//    - Correct press (key == 1<<replay[IDXW-1:0]): colour echoes key until release; score++ (hold at SCORE_MAX); idx++; replay steps.
//      - Pending is INPUT, or LEVEL_WIN if idx+1==L.
//    - Wrong press: echo key, no score change, pending=GAME_OVER.
//    - TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: GAME_OVER next cycle.
//  - LEVEL_WIN: screen=2.
//    - Press, L<MAX_LEN: pending=SHOW, level<=L+1.
//    - Press, L==MAX_LEN: pending=IDLE (game won).
//  - GAME_OVER: screen=3, score holds. Press: pending=IDLE.
//  - The sequence for a game is fully determined by game_seed, so SHOW and INPUT always agree.
//  - Counters are sized by $clog2 of their max values; no wrap in range.
//  - Key held through a state change: no new press is detected until release (edge rule).
// STRUCTURE
//  - colour_memory_defs.vh: state encodings, screen codes 0..3, LFSR taps.
//  - Sub-module galois_lfsr16: two instances.
//    - Free-running: enable=1.
//    - Replay: load/step inputs.
//  - The FSM and timers stay in this module; counters reuse UpCounterNbit where natural.
// TESTING (NUM_KEYS=4 MAX_LEN=3 START_LEN=2 FLASH=4 GAP=2 TIMEOUT=20)
//  1. Reset, then key=0001 for 3 cycles, release.
//     -> screen 1->0; showing=1; two 4-cycle flashes matching model LFSR replay of game_seed.
//  2. After show, press/release the model's 2 correct keys.
//     -> score 0->1->2; screen=2; level=2.
//     Then press/release -> level=3 and SHOW replays 3 colours, first two unchanged.
//  3. In INPUT press wrong key.
//     -> colour_onehot echoes it while held; on release screen=3; score unchanged.
//     Press/release -> screen=1.
//  4. In INPUT apply no key for 20 cycles -> screen=3 on cycle 21. TIMEOUT=0 -> INPUT persists.
//  5. Complete level 3 (MAX_LEN) -> screen=2; press/release -> IDLE.
//     Separately: assert reset during SHOW_ON -> next cycle screen=1, colour=0, score=0.
//  6. Keys pressed during SHOW are ignored (score/state unchanged).
//     Key held from SHOW into INPUT is not counted until released and re-pressed.

Source files
------------

// File: rtl/colour_sequence_engine_pkg.sv
// Shared encodings for the colour sequence game core: FSM states, screen codes, LFSR rule.
package colour_sequence_engine_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHOW_ON   = 3'd1;
  localparam logic [2:0] ST_SHOW_GAP  = 3'd2;
  localparam logic [2:0] ST_INPUT     = 3'd3;
  localparam logic [2:0] ST_PRESS     = 3'd4;
  localparam logic [2:0] ST_LEVEL_WIN = 3'd5;
  localparam logic [2:0] ST_GAME_OVER = 3'd6;

  // Screen codes understood by the pixel mux
  localparam logic [1:0] SCR_COLOUR = 2'd0;
  localparam logic [1:0] SCR_INTRO  = 2'd1;
  localparam logic [1:0] SCR_LEVEL  = 2'd2;
  localparam logic [1:0] SCR_OVER   = 2'd3;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/colour_sequence_engine_lfsr.sv
// 16-bit Galois LFSR with synchronous load and step enable.
module galois_lfsr16
  import colour_sequence_engine_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] q
);

  // Load has priority over stepping; reset returns to the seed
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= SEED;
    end else if (load) begin
      q <= load_value;
    end else if (enable) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/colour_sequence_engine.sv
// Simon-style game core: shows an LFSR-generated colour sequence, then checks keypresses.
module colour_sequence_engine
  import colour_sequence_engine_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned START_LEN      = 2,
  parameter int unsigned FLASH_CYCLES   = 25000000,
  parameter int unsigned GAP_CYCLES     = 5000000,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned SCORE_MAX      = 99,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] colour_onehot,
  output logic [1:0]          screen,
  output logic [7:0]          level,
  output logic [6:0]          score,
  output logic                showing
);

  localparam int unsigned KW     = NUM_KEYS;
  localparam int unsigned IDXW   = $clog2(NUM_KEYS);
  localparam int unsigned IW     = $clog2(MAX_LEN + 1);
  localparam int unsigned TMAX_A = (FLASH_CYCLES > GAP_CYCLES) ? FLASH_CYCLES : GAP_CYCLES;
  localparam int unsigned TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  logic [2:0]    state, state_nxt;
  logic [2:0]    pending, pending_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [15:0]   game_seed, seed_nxt;
  logic [KW-1:0] key_prev;
  logic [KW-1:0] colour_nxt;
  logic [1:0]    screen_nxt;
  logic [7:0]    level_nxt;
  logic [6:0]    score_nxt;
  logic          showing_nxt;
  logic [15:0]   free_q, replay_q;
  logic          rep_load, rep_step;
  logic          press;
  logic          last_entry;

  function automatic logic [KW-1:0] to_onehot(input logic [15:0] v);
    return KW'(1) << v[IDXW-1:0];
  endfunction

  galois_lfsr16 #(.SEED(LFSR_SEED)) u_free (
    .clock      (clock),
    .reset      (reset),
    .enable     (1'b1),
    .load       (1'b0),
    .load_value (16'h0000),
    .q          (free_q)
  );

  galois_lfsr16 #(.SEED(LFSR_SEED)) u_replay (
    .clock      (clock),
    .reset      (reset),
    .enable     (rep_step),
    .load       (rep_load),
    .load_value (game_seed),
    .q          (replay_q)
  );

  assign press      = (key != '0) && (key_prev == '0);
  assign last_entry = (8'(idx) + 8'd1) == level;

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    idx_nxt     = idx;
    timer_nxt   = timer;
    seed_nxt    = game_seed;
    colour_nxt  = colour_onehot;
    screen_nxt  = screen;
    level_nxt   = level;
    score_nxt   = score;
    showing_nxt = showing;
    rep_load    = 1'b0;
    rep_step    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press) begin
          seed_nxt    = (free_q == 16'h0000) ? 16'h0001 : free_q;
          score_nxt   = '0;
          level_nxt   = 8'(START_LEN);
          pending_nxt = ST_SHOW_ON;
          state_nxt   = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (key == '0) begin
          state_nxt   = pending;
          colour_nxt  = '0;
          showing_nxt = 1'b0;
          timer_nxt   = '0;
          case (pending)
            ST_SHOW_ON: begin
              rep_load    = 1'b1;
              idx_nxt     = '0;
              colour_nxt  = to_onehot(game_seed);
              showing_nxt = 1'b1;
              screen_nxt  = SCR_COLOUR;
            end
            ST_INPUT:     screen_nxt = SCR_COLOUR;
            ST_LEVEL_WIN: screen_nxt = SCR_LEVEL;
            ST_GAME_OVER: screen_nxt = SCR_OVER;
            default:      screen_nxt = SCR_INTRO;
          endcase
        end
      end
      ST_SHOW_ON: begin
        if (timer == TW'(FLASH_CYCLES - 1)) begin
          timer_nxt  = '0;
          colour_nxt = '0;
          state_nxt  = ST_SHOW_GAP;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      ST_SHOW_GAP: begin
        if (timer == TW'(GAP_CYCLES - 1)) begin
          timer_nxt = '0;
          if (last_entry) begin
            rep_load    = 1'b1;
            idx_nxt     = '0;
            showing_nxt = 1'b0;
            state_nxt   = ST_INPUT;
          end else begin
            rep_step   = 1'b1;
            idx_nxt    = idx + IW'(1);
            colour_nxt = to_onehot(lfsr_next(replay_q));
            state_nxt  = ST_SHOW_ON;
          end
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      ST_INPUT: begin
        if (press) begin
          timer_nxt  = '0;
          colour_nxt = key;
          state_nxt  = ST_PRESS;
          if (key == to_onehot(replay_q)) begin
            score_nxt   = (score == 7'(SCORE_MAX)) ? score : score + 7'd1;
            idx_nxt     = idx + IW'(1);
            rep_step    = 1'b1;
            pending_nxt = last_entry ? ST_LEVEL_WIN : ST_INPUT;
          end else begin
            pending_nxt = ST_GAME_OVER;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (timer == TW'(TIMEOUT_CYCLES - 1))) begin
          timer_nxt  = '0;
          screen_nxt = SCR_OVER;
          state_nxt  = ST_GAME_OVER;
        end else if (TIMEOUT_CYCLES != 0) begin
          timer_nxt = timer + TW'(1);
        end
      end
      ST_LEVEL_WIN: begin
        if (press) begin
          state_nxt = ST_PRESS;
          if (level < 8'(MAX_LEN)) begin
            level_nxt   = level + 8'd1;
            pending_nxt = ST_SHOW_ON;
          end else begin
            pending_nxt = ST_IDLE;
          end
        end
      end
      ST_GAME_OVER: begin
        if (press) begin
          pending_nxt = ST_IDLE;
          state_nxt   = ST_PRESS;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      pending       <= ST_IDLE;
      idx           <= '0;
      timer         <= '0;
      game_seed     <= LFSR_SEED;
      key_prev      <= '0;
      colour_onehot <= '0;
      screen        <= SCR_INTRO;
      level         <= 8'(START_LEN);
      score         <= '0;
      showing       <= 1'b0;
    end else begin
      state         <= state_nxt;
      pending       <= pending_nxt;
      idx           <= idx_nxt;
      timer         <= timer_nxt;
      game_seed     <= seed_nxt;
      key_prev      <= key;
      colour_onehot <= colour_nxt;
      screen        <= screen_nxt;
      level         <= level_nxt;
      score         <= score_nxt;
      showing       <= showing_nxt;
    end
  end

endmodule
